bit_serializer: RTL and testbench

//   Upstream feeder for the single-bit registered-output stage. Accepts a

---
 rtl/bit_serializer.sv | 136 +++++++++++++
 tb/tb_bit_serializer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder. Accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one registered bit per clock, with a done strobe.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LSB_FIRST = 1,
    parameter int unsigned GAP       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GW = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [GW-1:0]    gap_q,   gap_d;
    logic             out_q,   out_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;

    logic accept_c;
    logic last_c;

    assign last_c   = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
    // Ready depends only on state/count (and reset); the GAP==0 term enables back-to-back words.
    assign in_ready = !rst && ((state_q == S_IDLE) || ((GAP == 0) && last_c));
    assign accept_c = in_valid && in_ready;

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (last_c) begin
                    if (GAP > 0)       state_d = S_GAP;
                    else if (accept_c) state_d = S_SHIFT;
                    else               state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        busy_d      = (state_d != S_IDLE);

        if (accept_c) begin
            // First bit goes straight to the output flop; the rest is pre-shifted.
            if (LSB_FIRST != 0) begin
                out_d   = in_data[0];
                shift_d = in_data >> 1;
            end else begin
                out_d   = in_data[WIDTH-1];
                shift_d = in_data << 1;
            end
            out_valid_d = 1'b1;
            cnt_d       = '0;
            gap_d       = '0;
        end else if (state_q == S_SHIFT && !last_c) begin
            if (LSB_FIRST != 0) begin
                out_d   = shift_q[0];
                shift_d = shift_q >> 1;
            end else begin
                out_d   = shift_q[WIDTH-1];
                shift_d = shift_q << 1;
            end
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + CW'(1);
            done_d      = (cnt_d == CNT_LAST);
        end else if (last_c) begin
            cnt_d = '0;
            gap_d = '0;
        end else if (state_q == S_GAP) begin
            gap_d = (gap_q == GAP_LAST) ? '0 : gap_q + GW'(1);
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three configurations plus a one-flop
// downstream stage fed from the LSB-first, GAP=1 instance.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data, c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, b_ready, c_ready;
    logic       a_out, b_out, c_out;
    logic       a_ov, b_ov, c_ov;
    logic       a_done, b_done, c_done;
    logic       a_busy, b_busy, c_busy;
    logic       ds_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1), .GAP(1)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .out(a_out), .out_valid(a_ov), .done(a_done), .busy(a_busy));

    bit_serializer #(.WIDTH(8), .LSB_FIRST(0), .GAP(1)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .out(b_out), .out_valid(b_ov), .done(b_done), .busy(b_busy));

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1), .GAP(0)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .out(c_out), .out_valid(c_ov), .done(c_done), .busy(c_busy));

    // Single-bit registered-output stage driven by dut_a's serial bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ds_q <= 1'b0;
        else     ds_q <= a_out;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic probe(input int sel, output logic o, output logic ov,
                         output logic dn, output logic bz, output logic rdy);
        case (sel)
            0:       begin o = a_out; ov = a_ov; dn = a_done; bz = a_busy; rdy = a_ready; end
            1:       begin o = b_out; ov = b_ov; dn = b_done; bz = b_busy; rdy = b_ready; end
            default: begin o = c_out; ov = c_ov; dn = c_done; bz = c_busy; rdy = c_ready; end
        endcase
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            0:       begin a_valid = v; a_data = d; end
            1:       begin b_valid = v; b_data = d; end
            default: begin c_valid = v; c_data = d; end
        endcase
    endtask

    // seq[i] is the bit expected on 'out' in the i-th cycle after accept.
    task automatic run_word(input int sel, input logic [7:0] word,
                            input logic [7:0] seq, input int pulse_at);
        logic o, ov, dn, bz, rdy;
        @(negedge clk);
        probe(sel, o, ov, dn, bz, rdy);
        chk($sformatf("d%0d_idle_ready", sel), rdy, 1'b1);
        chk($sformatf("d%0d_idle_busy", sel), bz, 1'b0);
        chk($sformatf("d%0d_idle_ov", sel), ov, 1'b0);
        drive(sel, 1'b1, word);
        @(posedge clk);
        #1 drive(sel, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            probe(sel, o, ov, dn, bz, rdy);
            chk($sformatf("d%0d_w%02h_out%0d", sel, word, i), o, seq[i]);
            chk($sformatf("d%0d_w%02h_ov%0d", sel, word, i), ov, 1'b1);
            chk($sformatf("d%0d_w%02h_done%0d", sel, word, i), dn, (i == 7));
            chk($sformatf("d%0d_w%02h_busy%0d", sel, word, i), bz, 1'b1);
            chk($sformatf("d%0d_w%02h_ready%0d", sel, word, i), rdy, (sel == 2 && i == 7));
            if (sel == 0 && i > 0)
                chk($sformatf("ds_w%02h_%0d", word, i - 1), ds_q, seq[i-1]);
            if (i == pulse_at) drive(sel, 1'b1, 8'h3C);
            else               drive(sel, 1'b0, 8'h00);
        end
        if (sel != 2) begin
            @(negedge clk);
            probe(sel, o, ov, dn, bz, rdy);
            chk($sformatf("d%0d_gap_ov", sel), ov, 1'b0);
            chk($sformatf("d%0d_gap_out", sel), o, 1'b0);
            chk($sformatf("d%0d_gap_ready", sel), rdy, 1'b0);
            chk($sformatf("d%0d_gap_busy", sel), bz, 1'b1);
            chk($sformatf("d%0d_gap_done", sel), dn, 1'b0);
            if (sel == 0) chk($sformatf("ds_w%02h_7", word), ds_q, seq[7]);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_data = 8'h00; b_data = 8'h00; c_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_out", a_out, 1'b0);
        chk("rst_ov", a_ov, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_ready_a", a_ready, 1'b0);
        chk("rst_ready_c", c_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rel_ready_a", a_ready, 1'b1);
        chk("rel_ready_b", b_ready, 1'b1);

        // LSB first with one gap cycle; downstream stage checked alongside.
        run_word(0, 8'hA5, 8'hA5, -1);
        run_word(0, 8'h0F, 8'h0F, -1);
        // A 3C pulse during SHIFT must be ignored.
        run_word(0, 8'hC3, 8'hC3, 2);
        @(negedge clk);
        chk("ign_ov0", a_ov, 1'b0);
        chk("ign_busy0", a_busy, 1'b0);
        @(negedge clk);
        chk("ign_ov1", a_ov, 1'b0);
        chk("ign_busy1", a_busy, 1'b0);

        // MSB first.
        run_word(1, 8'hA5, 8'hA5, -1);
        run_word(1, 8'h01, 8'h80, -1);

        // GAP=0 back-to-back: FF then 00 with in_valid held high.
        @(negedge clk);
        c_data = 8'hFF;
        c_valid = 1'b1;
        @(posedge clk);
        #1 c_data = 8'h00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_out%0d", i), c_out, (i < 8));
            chk($sformatf("b2b_ov%0d", i), c_ov, 1'b1);
            chk($sformatf("b2b_done%0d", i), c_done, (i == 7 || i == 15));
            chk($sformatf("b2b_ready%0d", i), c_ready, (i == 7 || i == 15));
            if (i == 8) c_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_ov", c_ov, 1'b0);
        chk("b2b_end_busy", c_busy, 1'b0);
        chk("b2b_end_ready", c_ready, 1'b1);

        // Reset mid-SHIFT discards the word immediately.
        @(negedge clk);
        a_data = 8'hFF;
        a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_ov_pre", a_ov, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", a_out, 1'b0);
        chk("mid_rst_ov", a_ov, 1'b0);
        chk("mid_rst_done", a_done, 1'b0);
        chk("mid_rst_busy", a_busy, 1'b0);
        chk("mid_rst_ready", a_ready, 1'b0);
        chk("mid_rst_ds", ds_q, 1'b0);
        repeat (2) @(negedge clk);
        chk("mid_hold_ov", a_ov, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", a_ready, 1'b1);
        @(negedge clk);
        chk("mid_after_ov", a_ov, 1'b0);
        chk("mid_after_done", a_done, 1'b0);
        chk("mid_after_busy", a_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
